clock_correction_servo: RTL and testbench
=========================================

# clock_correction_servo

Computes the phase and frequency correction words for the synchronized clock counter. It sits directly upstream of the clock timing/correcting stage, accepting one signed time-offset sample per sync interval (master time minus local time, ns) and emitting one phase-step write or one frequency write per accepted sample. It runs a PI servo in 8.24 fixed-point ns-per-cycle units on a single clock domain.

## Interface
- CLK_PERIOD, 8'd8, nominal clock period in ns; nominal frequency word = {CLK_PERIOD, 24'h0}
- STEP_THRESH, 32'd1000, |offset| strictly above this in TRACK forces a phase step
- KP_SHIFT, 4, proportional gain = 2^-KP_SHIFT
- KI_SHIFT, 8, integral gain = 2^-KI_SHIFT
- MAX_ADJ, 32'h0040_0000, symmetric clamp on frequency deviation (8.24)

- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_servo_en  input  1  servo enable; low forces IDLE
- iv_offset  input  32  signed two's-complement offset, ns
- i_offset_wr  input  1  one-cycle strobe qualifying iv_offset
- ov_phase_cor  output  32  sign-magnitude: bit31=1 subtract, [30:0] magnitude
- o_phase_cor_wr  output  1  one-cycle write strobe
- ov_frequency_cor  output  32  8.24 ns-per-cycle increment
- o_frequency_cor_wr  output  1  one-cycle write strobe
- ov_drop_cnt  output  16  saturating count of samples dropped while busy
- ov_servo_state  output  2  2'd0 IDLE, 2'd1 TRACK

## Operation
- Reset values: ov_phase_cor 0, both write strobes 0, ov_frequency_cor {CLK_PERIOD,24'h0}, ov_drop_cnt 0, state IDLE, integrator 0.
- IDLE: the first accepted sample always produces a phase step. Integrator cleared. Next state TRACK.
- TRACK, |offset| > STEP_THRESH: phase step, integrator cleared, no frequency write.
- TRACK, |offset| <= STEP_THRESH: integrator += offset (40-bit signed, saturating at ±(2^39−1)).
  - p = (offset·2^24) >>> KP_SHIFT.
  - i = (integrator·2^24) >>> KI_SHIFT.
  - Both computed in 72-bit signed arithmetic.
  - delta = p + i, clamped to [−MAX_ADJ, +MAX_ADJ].
  - ov_frequency_cor = nominal + delta, with one frequency write.
- Phase step word:
  - Sign bit = 1 when offset is negative.
  - Magnitude = |offset|, saturated to 31'h7FFF_FFFF. This covers offset 32'h8000_0000.
- ov_frequency_cor and ov_phase_cor hold their last written value between strobes.
- At most one of the two write strobes is active in any cycle.
- i_servo_en low:
  - State goes to IDLE and the integrator is cleared.
  - The in-flight sample is discarded with no strobe.
  - ov_frequency_cor returns to nominal with no strobe.

## Timing
- Sample accepted at cycle T (i_offset_wr high, not busy). T+1: magnitude, p, i and integrator computed and registered. T+2: chosen strobe high for exactly one cycle, with data valid the same cycle.
- Busy during T+1 and T+2. A strobe in either cycle is dropped and ov_drop_cnt increments, saturating at 16'hFFFF. A strobe at T+3 is accepted.
- Same cycle i_servo_en low and i_offset_wr high: disable wins. The sample is discarded and not counted as dropped.
- State update (IDLE→TRACK) takes effect at T+2, together with the strobe.
- Reset asserted mid-pipeline: all outputs return to reset values on the next edge. No strobe is emitted for the in-flight sample.

## Configuration
- SERVO_INTEGRAL_EN defined: the integrator and i term are built exactly as above.
- Undefined: no integrator register, delta = p only (still clamped), and phase-step integrator clearing is a no-op.
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset check (defaults): i_rst held 3 cycles -> ov_frequency_cor 32'h0800_0000, ov_phase_cor 0, strobes 0, ov_drop_cnt 0, ov_servo_state 0.
- First sample: offset +1000 -> at T+2, o_phase_cor_wr with 32'h0000_03E8, no frequency strobe; ov_servo_state becomes 1.
- Small offset, macro defined: next offset −2 -> at T+2, o_frequency_cor_wr with 32'h07DE_0000 (p = −0x20_0000, i = −0x2_0000). Without the macro, the same stimulus gives 32'h07E0_0000.
- Clamp: in TRACK, offset +500 -> frequency write 32'h0840_0000.
- Large steps: offset −5000 -> phase write 32'h8000_1388 and the integrator clears. Offset 32'h8000_0000 -> 32'hFFFF_FFFF.
- Busy and disable: i_offset_wr high three consecutive cycles -> one strobe, ov_drop_cnt = 2. i_servo_en dropped at T+1 -> no strobe, state 0, ov_frequency_cor 32'h0800_0000.

Source files
------------

// File: rtl/clock_correction_servo.sv
// clock_correction_servo: PI servo turning time-offset samples into phase-step or 8.24 frequency writes.
// Integral path is built only when SERVO_INTEGRAL_EN is defined.
module clock_correction_servo #(
  parameter logic [7:0]  CLK_PERIOD  = 8'd8,
  parameter logic [31:0] STEP_THRESH = 32'd1000,
  parameter int          KP_SHIFT    = 4,
  parameter int          KI_SHIFT    = 8,
  parameter logic [31:0] MAX_ADJ     = 32'h0040_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_servo_en,
  input  logic [31:0] iv_offset,
  input  logic        i_offset_wr,
  output logic [31:0] ov_phase_cor,
  output logic        o_phase_cor_wr,
  output logic [31:0] ov_frequency_cor,
  output logic        o_frequency_cor_wr,
  output logic [15:0] ov_drop_cnt,
  output logic [1:0]  ov_servo_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1} state_t;
  localparam logic [31:0] NOMINAL = {CLK_PERIOD, 24'h0};
  localparam logic signed [71:0] ADJ_HI = {40'd0, MAX_ADJ};
  localparam logic signed [71:0] ADJ_LO = -ADJ_HI;
  localparam logic [31:0] ADJ_NEG = ~MAX_ADJ + 32'd1;
  state_t r_state, w_state_nxt;
  logic r_v1, r_step, r_neg, r_phase_wr, r_freq_wr;
  logic [30:0] r_mag;
  logic signed [71:0] r_p;
  logic [31:0] r_phase_cor, r_freq_cor;
  logic [15:0] r_drop_cnt;
  logic w_busy, w_acc, w_step;
  logic [31:0] w_abs, w_delta;
  logic [30:0] w_mag;
  logic signed [71:0] w_off72, w_p, w_i_q, w_sum;
  assign w_busy  = r_v1 | r_phase_wr | r_freq_wr;
  assign w_acc   = i_offset_wr & i_servo_en & ~w_busy;
  assign w_abs   = iv_offset[31] ? ~iv_offset + 32'd1 : iv_offset;
  assign w_mag   = w_abs[31] ? 31'h7FFF_FFFF : w_abs[30:0];
  assign w_step  = (r_state == IDLE) | (w_abs > STEP_THRESH);
  assign w_off72 = {{40{iv_offset[31]}}, iv_offset};
  assign w_p     = (w_off72 <<< 24) >>> KP_SHIFT;
  assign w_sum   = r_p + w_i_q;
  assign w_delta = (w_sum > ADJ_HI) ? MAX_ADJ : (w_sum < ADJ_LO) ? ADJ_NEG : w_sum[31:0];
`ifdef SERVO_INTEGRAL_EN
  localparam logic signed [40:0] INT_HI = 41'sh07F_FFFF_FFFF;
  localparam logic signed [40:0] INT_LO = -INT_HI;
  logic signed [39:0] r_integ, w_integ_nxt;
  logic signed [40:0] w_isum;
  logic signed [71:0] w_integ72, w_i, r_i;
  assign w_isum      = {r_integ[39], r_integ} + {{9{iv_offset[31]}}, iv_offset};
  assign w_integ_nxt = w_step ? '0 : (w_isum > INT_HI) ? INT_HI[39:0] : (w_isum < INT_LO) ? INT_LO[39:0] : w_isum[39:0];
  assign w_integ72   = {{32{w_integ_nxt[39]}}, w_integ_nxt};
  assign w_i         = (w_integ72 <<< 24) >>> KI_SHIFT;
  assign w_i_q       = r_i;
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_servo_en) begin
      r_integ <= '0;
      r_i     <= '0;
    end else if (w_acc) begin
      r_integ <= w_integ_nxt;
      r_i     <= w_i;
    end
  end
`else
  assign w_i_q = '0;
`endif
  always_comb begin
    w_state_nxt = !i_servo_en ? IDLE : r_v1 ? TRACK : r_state;
  end
  always_ff @(posedge i_clk) begin
    r_state <= i_rst ? IDLE : w_state_nxt;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1        <= 1'b0;
      r_step      <= 1'b0;
      r_neg       <= 1'b0;
      r_mag       <= '0;
      r_p         <= '0;
      r_phase_wr  <= 1'b0;
      r_freq_wr   <= 1'b0;
      r_phase_cor <= '0;
      r_freq_cor  <= NOMINAL;
      r_drop_cnt  <= '0;
    end else if (!i_servo_en) begin
      r_v1       <= 1'b0;
      r_phase_wr <= 1'b0;
      r_freq_wr  <= 1'b0;
      r_freq_cor <= NOMINAL;
    end else begin
      r_v1       <= w_acc;
      r_phase_wr <= r_v1 & r_step;
      r_freq_wr  <= r_v1 & ~r_step;
      if (w_acc) begin
        r_step <= w_step;
        r_neg  <= iv_offset[31];
        r_mag  <= w_mag;
        r_p    <= w_p;
      end
      if (r_v1 & r_step) r_phase_cor <= {r_neg, r_mag};
      if (r_v1 & ~r_step) r_freq_cor <= NOMINAL + w_delta;
      if (i_offset_wr & w_busy & ~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
  assign ov_phase_cor       = r_phase_cor;
  assign o_phase_cor_wr     = r_phase_wr;
  assign ov_frequency_cor   = r_freq_cor;
  assign o_frequency_cor_wr = r_freq_wr;
  assign ov_drop_cnt        = r_drop_cnt;
  assign ov_servo_state     = r_state;
endmodule

// File: tb/tb_clock_correction_servo.sv
// tb_clock_correction_servo: directed stimulus with a strobe scoreboard for clock_correction_servo.
module tb_clock_correction_servo;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, wr = 1'b0;
  logic [31:0] offset = '0;
  logic [31:0] phase_cor, freq_cor;
  logic phase_wr, freq_wr;
  logic [15:0] drop_cnt;
  logic [1:0] state;
  int cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct {logic ph; logic [31:0] val; int cyc;} exp_t;
  exp_t q[$];
`ifdef SERVO_INTEGRAL_EN
  localparam logic [31:0] SMALL_NEG2 = 32'h07DE_0000;
`else
  localparam logic [31:0] SMALL_NEG2 = 32'h07E0_0000;
`endif
  clock_correction_servo dut (
    .i_clk(clk), .i_rst(rst), .i_servo_en(en), .iv_offset(offset), .i_offset_wr(wr),
    .ov_phase_cor(phase_cor), .o_phase_cor_wr(phase_wr),
    .ov_frequency_cor(freq_cor), .o_frequency_cor_wr(freq_wr),
    .ov_drop_cnt(drop_cnt), .ov_servo_state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] off, input logic ph, input logic [31:0] val);
    offset = off;
    wr = 1'b1;
    q.push_back('{ph, val, cyc + 2});
    tick(1);
    wr = 1'b0;
    tick(2);
  endtask
  always @(negedge clk) begin
    if (!rst && (phase_wr || freq_wr)) begin
      if (q.size() == 0) chk("unexpected_strobe", {30'd0, freq_wr, phase_wr}, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind", {30'd0, freq_wr, phase_wr}, e.ph ? 32'd1 : 32'd2);
        chk("strobe_data", e.ph ? phase_cor : freq_cor, e.val);
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  end
  initial begin
    tick(3);
    chk("rst_freq", freq_cor, 32'h0800_0000);
    chk("rst_phase", phase_cor, 32'h0);
    chk("rst_strobes", {30'd0, freq_wr, phase_wr}, 32'h0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'h0);
    chk("rst_state", {30'd0, state}, 32'h0);
    rst = 1'b0;
    en = 1'b1;
    tick(1);
    send(32'd1000, 1'b1, 32'h0000_03E8);
    chk("state_track", {30'd0, state}, 32'd1);
    send(-32'sd2, 1'b0, SMALL_NEG2);
    send(32'd500, 1'b0, 32'h0840_0000);
    send(-32'sd5000, 1'b1, 32'h8000_1388);
    send(-32'sd2, 1'b0, SMALL_NEG2);
    send(32'h8000_0000, 1'b1, 32'hFFFF_FFFF);
    send(-32'sd1000, 1'b0, 32'h07C0_0000);
    send(32'd1001, 1'b1, 32'h0000_03E9);
    offset = 32'd16;
    wr = 1'b1;
    q.push_back('{1'b0, 32'h0840_0000, cyc + 2});
    tick(3);
    wr = 1'b0;
    tick(2);
    chk("drop_two", {16'd0, drop_cnt}, 32'd2);
    chk("freq_hold", freq_cor, 32'h0840_0000);
    offset = 32'd20;
    wr = 1'b1;
    tick(1);
    wr = 1'b0;
    en = 1'b0;
    tick(1);
    en = 1'b1;
    chk("dis_state", {30'd0, state}, 32'd0);
    chk("dis_freq", freq_cor, 32'h0800_0000);
    tick(3);
    en = 1'b0;
    wr = 1'b1;
    tick(1);
    wr = 1'b0;
    en = 1'b1;
    tick(1);
    chk("dis_no_drop", {16'd0, drop_cnt}, 32'd2);
    send(32'd5, 1'b1, 32'h0000_0005);
    offset = 32'd7;
    wr = 1'b1;
    tick(1);
    wr = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    chk("rst_mid_state", {30'd0, state}, 32'd0);
    chk("rst_mid_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_mid_phase", phase_cor, 32'h0);
    chk("sb_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
